execute_ldst_access: RTL and testbench

Load/store access sequencer that sits directly downstream of the execute-stage load/store address/data generator. It registers one decoded LDST operation (rw, PDT, address, store data, order, load shift, byte mask), drives it onto the data-memory request port with a req/busy handshake, and waits for the memory response. For loads it right-aligns and zero-extends the returned word before presenting it to writeback. Only one access is outstanding at a time, and flush is supported at any point.

---
 rtl/execute_ldst_access.sv | 222 ++++++++++++++++++++++
 tb/tb_execute_ldst_access.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_ldst_access.sv
// execute_ldst_access
// Load/store access sequencer placed after the execute-stage LDST generator.
// It latches one decoded operation, issues it on the data-memory request port
// (req/busy handshake), waits for the single response and hands a right-aligned,
// zero-extended load word (or 0 for stores) to writeback as a one-cycle pulse.
// Optional feature: define MIST1032ISA_LDST_ALIGN_FAULT_EN to turn empty-mask
// and misaligned word accesses into immediate alignment faults (no bus request).
module execute_ldst_access (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iVALID,
  output logic        oBUSY,
  input  logic        iLDST_RW,
  input  logic [31:0] iLDST_PDT,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  input  logic [1:0]  iLDST_ORDER,
  input  logic [1:0]  iLOAD_SHIFT,
  input  logic [3:0]  iLOAD_MASK,
  output logic        oDATAIO_REQ,
  input  logic        iDATAIO_BUSY,
  output logic        oDATAIO_RW,
  output logic [31:0] oDATAIO_PDT,
  output logic [31:0] oDATAIO_ADDR,
  output logic [31:0] oDATAIO_DATA,
  output logic [1:0]  oDATAIO_ORDER,
  output logic [3:0]  oDATAIO_MASK,
  input  logic        iDATAIO_REQ,
  input  logic [31:0] iDATAIO_DATA,
  output logic        oVALID,
  output logic        oRW,
  output logic [31:0] oDATA,
  output logic        oFAULT
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // Latched operation (drives the memory request bus directly)
  logic        rw_q;
  logic [31:0] pdt_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  order_q;
  logic [1:0]  shift_q;
  logic [3:0]  mask_q;

  // Completion results, held until the next completion
  logic        orw_q, orw_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept_s;
  logic        capture_s;
  logic        align_fault_s;

  // Right-align the response word to the load lane and zero-extend by size.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  shift,
                                           input logic [1:0]  order);
    logic [31:0] s;
    s = word >> {shift, 3'b000};
    case (order)
      2'd0:    fmt_load = {24'h000000, s[7:0]};
      2'd1:    fmt_load = {16'h0000, s[15:0]};
      default: fmt_load = s;
    endcase
  endfunction

`ifdef MIST1032ISA_LDST_ALIGN_FAULT_EN
  logic fault_q;

  assign align_fault_s = (iLOAD_MASK == 4'h0) ||
                         ((iLDST_ORDER == 2'd2) && (iLDST_ADDR[1:0] != 2'b00));

  // Remember whether the accepted operation is an alignment fault.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      fault_q <= 1'b0;
    end else if (accept_s) begin
      fault_q <= align_fault_s;
    end
  end

  assign oFAULT = oVALID && fault_q;
`else
  assign align_fault_s = 1'b0;
  assign oFAULT        = 1'b0;
`endif

  // Next-state and completion-capture logic.
  always_comb begin
    state_d   = state_q;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    orw_d     = orw_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (iVALID && !iFLUSH) begin
          accept_s = 1'b1;
          if (align_fault_s) begin
            // Faulting op completes directly with zero data.
            capture_s = 1'b1;
            orw_d     = iLDST_RW;
            rdata_d   = 32'h0000_0000;
            state_d   = ST_DONE;
          end else begin
            state_d   = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (iFLUSH) begin
          // A request handed off in the flush cycle still owes a response.
          if (!iDATAIO_BUSY) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!iDATAIO_BUSY) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (iFLUSH) begin
          if (iDATAIO_REQ) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (iDATAIO_REQ) begin
          capture_s = 1'b1;
          orw_d     = rw_q;
          rdata_d   = rw_q ? 32'h0000_0000 : fmt_load(iDATAIO_DATA, shift_q, order_q);
          state_d   = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (iDATAIO_REQ) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch all operation fields on accept; they stay stable through REQ.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rw_q    <= 1'b0;
      pdt_q   <= 32'h0000_0000;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      order_q <= 2'd0;
      shift_q <= 2'd0;
      mask_q  <= 4'h0;
    end else if (accept_s) begin
      rw_q    <= iLDST_RW;
      pdt_q   <= iLDST_PDT;
      addr_q  <= iLDST_ADDR;
      data_q  <= iLDST_DATA;
      order_q <= iLDST_ORDER;
      shift_q <= iLOAD_SHIFT;
      mask_q  <= iLOAD_MASK;
    end
  end

  // Capture completion results when entering DONE.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      orw_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else if (capture_s) begin
      orw_q   <= orw_d;
      rdata_q <= rdata_d;
    end
  end

  assign oBUSY         = (state_q != ST_IDLE);
  assign oDATAIO_REQ   = (state_q == ST_REQ);
  assign oDATAIO_RW    = rw_q;
  assign oDATAIO_PDT   = pdt_q;
  assign oDATAIO_ADDR  = addr_q;
  assign oDATAIO_DATA  = data_q;
  assign oDATAIO_ORDER = order_q;
  assign oDATAIO_MASK  = mask_q;
  // A flush in the DONE cycle suppresses the completion pulse.
  assign oVALID        = (state_q == ST_DONE) && !iFLUSH;
  assign oRW           = orw_q;
  assign oDATA         = rdata_q;

endmodule

// File: tb/tb_execute_ldst_access.sv
// Self-checking bench for execute_ldst_access: directed vector table,
// hand-written flush/reset sequences and randomized operations checked
// against a transaction-level reference model.
module tb_execute_ldst_access;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid_i;
  logic        busy_o;
  logic        ldst_rw;
  logic [31:0] ldst_pdt;
  logic [31:0] ldst_addr;
  logic [31:0] ldst_data;
  logic [1:0]  ldst_order;
  logic [1:0]  load_shift;
  logic [3:0]  load_mask;
  logic        dio_req_o;
  logic        dio_busy;
  logic        dio_rw_o;
  logic [31:0] dio_pdt_o;
  logic [31:0] dio_addr_o;
  logic [31:0] dio_data_o;
  logic [1:0]  dio_order_o;
  logic [3:0]  dio_mask_o;
  logic        dio_resp;
  logic [31:0] dio_rdata;
  logic        valid_o;
  logic        rw_o;
  logic [31:0] data_o;
  logic        fault_o;

  int checks = 0;
  int passes = 0;

  execute_ldst_access dut (
    .iCLOCK       (clk),
    .inRESET      (rst_n),
    .iFLUSH       (flush),
    .iVALID       (valid_i),
    .oBUSY        (busy_o),
    .iLDST_RW     (ldst_rw),
    .iLDST_PDT    (ldst_pdt),
    .iLDST_ADDR   (ldst_addr),
    .iLDST_DATA   (ldst_data),
    .iLDST_ORDER  (ldst_order),
    .iLOAD_SHIFT  (load_shift),
    .iLOAD_MASK   (load_mask),
    .oDATAIO_REQ  (dio_req_o),
    .iDATAIO_BUSY (dio_busy),
    .oDATAIO_RW   (dio_rw_o),
    .oDATAIO_PDT  (dio_pdt_o),
    .oDATAIO_ADDR (dio_addr_o),
    .oDATAIO_DATA (dio_data_o),
    .oDATAIO_ORDER(dio_order_o),
    .oDATAIO_MASK (dio_mask_o),
    .iDATAIO_REQ  (dio_resp),
    .iDATAIO_DATA (dio_rdata),
    .oVALID       (valid_o),
    .oRW          (rw_o),
    .oDATA        (data_o),
    .oFAULT       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  order;
    logic [1:0]  shift;
    logic [3:0]  mask;
    int          busy;
    int          delay;
    logic [31:0] resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got=%h expected=%h", nm, got, exp);
  endtask

  // Reference model: load result is the response viewed from the selected
  // byte lane upward, truncated to the access size; stores return zero.
  function automatic logic [31:0] ref_data(input logic rw, input logic [1:0] order,
                                           input logic [1:0] shift, input logic [31:0] w);
    longint unsigned v;
    if (rw) return 32'h0;
    v = longint'(w) / (64'd1 << (8 * int'(shift)));
    if (order == 2'd0) v = v % 256;
    else if (order == 2'd1) v = v % 65536;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; flush = 1'b0; dio_busy = 1'b0; dio_resp = 1'b0;
  endtask

  task automatic drive_op(input logic rw, input logic [31:0] pdt, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] order,
                          input logic [1:0] shift, input logic [3:0] mask);
    valid_i = 1'b1; ldst_rw = rw; ldst_pdt = pdt; ldst_addr = addr;
    ldst_data = wdata; ldst_order = order; load_shift = shift; load_mask = mask;
  endtask

  // One complete operation with a planned bus schedule: busy for 'busy'
  // request cycles, response 'delay' cycles after the hand-off.
  task automatic run_op(input string nm, input logic rw, input logic [31:0] pdt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] order, input logic [1:0] shift,
                        input logic [3:0] mask, input int busy, input int delay,
                        input logic [31:0] resp, input bit hold);
    int exp_cyc, vcnt, vcyc, reqcnt, bad;
    logic [31:0] got_data;
    logic        got_rw;
    exp_cyc = 3 + busy + delay;
    vcnt = 0; vcyc = -1; reqcnt = 0; bad = 0; got_data = 32'h0; got_rw = 1'b0;
    @(negedge clk);
    idle_inputs();
    drive_op(rw, pdt, addr, wdata, order, shift, mask);
    #1;
    chk({nm, "_idle_before"}, {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    for (int c = 1; c <= exp_cyc + 1; c++) begin
      @(negedge clk);
      valid_i   = hold;
      dio_busy  = (c <= busy);
      dio_resp  = (c == 2 + busy + delay);
      dio_rdata = (c == 2 + busy + delay) ? resp : $urandom;
      #1;
      if (dio_req_o) begin
        reqcnt++;
        if ({dio_rw_o, dio_pdt_o, dio_addr_o, dio_data_o, dio_order_o, dio_mask_o} !==
            {rw, pdt, addr, wdata, order, mask}) bad++;
      end
      if (c <= exp_cyc && !busy_o) bad++;
      if (valid_o) begin
        vcnt++; vcyc = c; got_data = data_o; got_rw = rw_o;
        if (fault_o !== 1'b0) bad++;
      end
      if (c == exp_cyc + 1) chk({nm, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    end
    dio_resp = 1'b0; dio_busy = 1'b0;
    chk({nm, "_valid_count"}, vcnt, 32'd1);
    chk({nm, "_valid_cycle"}, vcyc, exp_cyc);
    chk({nm, "_data"}, got_data, ref_data(rw, order, shift, resp));
    chk({nm, "_rw"}, {31'd0, got_rw}, {31'd0, rw});
    chk({nm, "_req_cycles"}, reqcnt, busy + 1);
    chk({nm, "_bus_busy_errs"}, bad, 32'd0);
  endtask

  // Accept a plain load word; returns right after the accept edge.
  task automatic accept_load(input logic [31:0] addr);
    @(negedge clk);
    idle_inputs();
    drive_op(1'b0, 32'h0000_1000, addr, 32'h0, 2'd2, 2'd0, 4'hF);
    @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{"ld_byte",   1'b0, 32'h0000_1003, 32'h0,         2'd0, 2'd3, 4'b1000, 0, 0, 32'hAB11_2233, 32'h0000_00AB};
    vecs[1] = '{"st_half",   1'b1, 32'h0000_2002, 32'h1234_0000, 2'd1, 2'd2, 4'b1100, 3, 0, 32'h5555_5555, 32'h0000_0000};
    vecs[2] = '{"ld_word",   1'b0, 32'h0000_3000, 32'h0,         2'd2, 2'd0, 4'b1111, 0, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{"ld_half1",  1'b0, 32'h0000_4001, 32'h0,         2'd1, 2'd1, 4'b0110, 1, 2, 32'h1122_3344, 32'h0000_2233};
    vecs[4] = '{"ld_ord3",   1'b0, 32'h0000_5000, 32'h0,         2'd3, 2'd2, 4'b1111, 2, 1, 32'hCAFE_F00D, 32'h0000_CAFE};
    vecs[5] = '{"ld_byte0",  1'b0, 32'h0000_6000, 32'h0,         2'd0, 2'd0, 4'b0001, 0, 3, 32'h1234_56FF, 32'h0000_00FF};

    rst_n = 1'b0;
    idle_inputs();
    drive_op(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 4'h0);
    valid_i = 1'b0;
    dio_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs",
        {22'd0, busy_o, dio_req_o, dio_rw_o, dio_order_o, dio_mask_o, valid_o, rw_o, fault_o},
        32'd0);
    chk("reset_bus_or", dio_pdt_o | dio_addr_o | dio_data_o | data_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table; the table's expectations cross-check the model.
    for (int i = 0; i < 6; i++) begin
      chk({vecs[i].name, "_model"},
          ref_data(vecs[i].rw, vecs[i].order, vecs[i].shift, vecs[i].resp), vecs[i].exp_data);
      run_op(vecs[i].name, vecs[i].rw, 32'hA000_0000 + i, vecs[i].addr, vecs[i].wdata,
             vecs[i].order, vecs[i].shift, vecs[i].mask, vecs[i].busy, vecs[i].delay,
             vecs[i].resp, 1'b0);
    end

    // Upstream holds iVALID through a whole op: next accept only after DONE.
    run_op("hold", 1'b0, 32'h0, 32'h0000_7000, 32'h0, 2'd2, 2'd0, 4'hF, 0, 4, 32'h0BAD_F00D, 1'b1);
    @(negedge clk); valid_i = 1'b0; #1;
    chk("hold_second_req", {30'd0, busy_o, dio_req_o}, 32'd3);
    @(negedge clk); dio_resp = 1'b1; dio_rdata = 32'h0BAD_F00D; #1;
    @(negedge clk); dio_resp = 1'b0; #1;
    chk("hold_second_valid", {31'd0, valid_o}, 32'd1);
    chk("hold_second_data", data_o, 32'h0BAD_F00D);

    // Flush in WAIT, response two cycles later.
    accept_load(32'h0000_8000);
    @(negedge clk); valid_i = 1'b0; #1;
    chk("fwait_req", {31'd0, dio_req_o}, 32'd1);
    @(negedge clk); flush = 1'b1; #1;
    chk("fwait_novalid_c2", {31'd0, valid_o}, 32'd0);
    @(negedge clk); flush = 1'b0; #1;
    chk("fwait_busy_c3", {30'd0, busy_o, valid_o}, 32'd2);
    @(negedge clk); dio_resp = 1'b1; dio_rdata = 32'h7777_7777; #1;
    chk("fwait_busy_c4", {30'd0, busy_o, valid_o}, 32'd2);
    @(negedge clk); dio_resp = 1'b0; #1;
    chk("fwait_idle_c5", {30'd0, busy_o, valid_o}, 32'd0);
    run_op("after_fwait", 1'b0, 32'h1, 32'h0000_8004, 32'h0, 2'd2, 2'd0, 4'hF, 0, 0, 32'h0102_0304, 1'b0);

    // Flush and response in the same WAIT cycle.
    accept_load(32'h0000_9000);
    @(negedge clk); valid_i = 1'b0; #1;
    @(negedge clk); flush = 1'b1; dio_resp = 1'b1; #1;
    chk("fresp_novalid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); flush = 1'b0; dio_resp = 1'b0; #1;
    chk("fresp_idle", {30'd0, busy_o, valid_o}, 32'd0);

    // Flush in REQ while memory busy: back to IDLE, no request.
    accept_load(32'h0000_A000);
    @(negedge clk); valid_i = 1'b0; dio_busy = 1'b1; flush = 1'b1; #1;
    @(negedge clk); dio_busy = 1'b0; flush = 1'b0; #1;
    chk("freq_busy_idle", {30'd0, busy_o, dio_req_o}, 32'd0);

    // Flush in REQ during hand-off: response still owed, then dropped.
    accept_load(32'h0000_B000);
    @(negedge clk); valid_i = 1'b0; flush = 1'b1; #1;
    @(negedge clk); flush = 1'b0; #1;
    chk("freq_take_discard", {30'd0, busy_o, dio_req_o}, 32'd2);
    @(negedge clk); dio_resp = 1'b1; #1;
    chk("freq_take_novalid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); dio_resp = 1'b0; #1;
    chk("freq_take_idle", {30'd0, busy_o, valid_o}, 32'd0);

    // Flush in DONE suppresses oVALID.
    accept_load(32'h0000_C000);
    @(negedge clk); valid_i = 1'b0; #1;
    @(negedge clk); dio_resp = 1'b1; #1;
    @(negedge clk); dio_resp = 1'b0; flush = 1'b1; #1;
    chk("fdone_suppressed", {31'd0, valid_o}, 32'd0);
    @(negedge clk); flush = 1'b0; #1;
    chk("fdone_idle", {30'd0, busy_o, valid_o}, 32'd0);

    // Flush in IDLE blocks the accept.
    @(negedge clk); drive_op(1'b0, 32'h0, 32'h0000_D000, 32'h0, 2'd2, 2'd0, 4'hF); flush = 1'b1; #1;
    @(negedge clk); idle_inputs(); #1;
    chk("fidle_no_accept", {30'd0, busy_o, dio_req_o}, 32'd0);

    // Reset mid-REQ, then a stray response is ignored.
    accept_load(32'h0000_E000);
    @(negedge clk); valid_i = 1'b0; dio_busy = 1'b1; #1;
    rst_n = 1'b0; #1;
    chk("rst_mid_flags", {26'd0, busy_o, dio_req_o, dio_rw_o, valid_o, rw_o, fault_o}, 32'd0);
    chk("rst_mid_bus", dio_addr_o | dio_data_o | dio_pdt_o | data_o, 32'd0);
    @(negedge clk); rst_n = 1'b1; dio_busy = 1'b0; dio_resp = 1'b1; #1;
    @(negedge clk); dio_resp = 1'b0; #1;
    chk("rst_stray_resp", {30'd0, busy_o, valid_o}, 32'd0);

`ifdef MIST1032ISA_LDST_ALIGN_FAULT_EN
    @(negedge clk); idle_inputs(); drive_op(1'b0, 32'h0, 32'h0000_F000, 32'h0, 2'd1, 2'd0, 4'h0);
    @(posedge clk);
    @(negedge clk); valid_i = 1'b0; #1;
    chk("fault_flags", {29'd0, dio_req_o, valid_o, fault_o}, 32'd3);
    chk("fault_data", data_o, 32'd0);
    @(negedge clk); #1;
    chk("fault_idle", {31'd0, busy_o}, 32'd0);
`endif

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic        r_rw;
      logic [1:0]  r_order;
      logic [31:0] r_addr;
      r_rw    = 1'($urandom_range(0, 1));
      r_order = 2'($urandom_range(0, 3));
      r_addr  = $urandom;
      if (r_order == 2'd2) r_addr[1:0] = 2'b00;
      run_op("rand", r_rw, $urandom, r_addr, $urandom, r_order,
             2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
